// File: rtl/pea_pkg.sv
// Shared constants and types for the Processing Element Array and its context scheduler.
package pea_pkg;

    localparam int N_PE          = 16;
    localparam int LOG_N_PE      = $clog2(N_PE);
    localparam int N_CFG_BITS_PE = 8;

    localparam int N_CTX     = 8;
    localparam int LOG_N_CTX = $clog2(N_CTX);
    localparam int ITER_W    = 16;
    localparam int DRAIN_W   = 4;

    // All-zero control word is the PE no-operation.
    localparam logic [N_CFG_BITS_PE-1:0] CTRL_NOP = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pea_sched_state_t;

endpackage

// File: rtl/pea_ctx_sched_if.sv
// Configuration, control and status bundle between a host and the PEA context scheduler.
interface pea_ctx_sched_if #(
    parameter int N_PE    = pea_pkg::N_PE,
    parameter int N_CTX   = pea_pkg::N_CTX,
    parameter int CFG_W   = pea_pkg::N_CFG_BITS_PE,
    parameter int ITER_W  = pea_pkg::ITER_W,
    parameter int DRAIN_W = pea_pkg::DRAIN_W
);

    logic                       cfg_we_i;
    logic [$clog2(N_CTX)-1:0]   cfg_ctx_i;
    logic [$clog2(N_PE)-1:0]    cfg_pe_i;
    logic [CFG_W-1:0]           cfg_data_i;
    logic                       start_i;
    logic                       stop_i;
    logic [$clog2(N_CTX)-1:0]   n_ctx_i;
    logic [ITER_W-1:0]          n_iter_i;
    logic [DRAIN_W-1:0]         n_drain_i;
    logic                       pea_ready_i;

    logic [N_PE*CFG_W-1:0]      ctrl_pe_o;
    logic [$clog2(N_CTX)-1:0]   ctx_idx_o;
    logic [ITER_W-1:0]          iter_cnt_o;
    logic                       busy_o;
    logic                       done_o;
    logic                       cfg_err_o;

    modport master (
        output cfg_we_i, cfg_ctx_i, cfg_pe_i, cfg_data_i,
        output start_i, stop_i, n_ctx_i, n_iter_i, n_drain_i, pea_ready_i,
        input  ctrl_pe_o, ctx_idx_o, iter_cnt_o, busy_o, done_o, cfg_err_o
    );

    modport slave (
        input  cfg_we_i, cfg_ctx_i, cfg_pe_i, cfg_data_i,
        input  start_i, stop_i, n_ctx_i, n_iter_i, n_drain_i, pea_ready_i,
        output ctrl_pe_o, ctx_idx_o, iter_cnt_o, busy_o, done_o, cfg_err_o
    );

endinterface

// File: rtl/pea_ctx_mem.sv
// Context memory: one row of per-PE control words per context slot, written one word at a time
// and read a full row at a time, with a write-first bypass so a same-cycle write is visible.
module pea_ctx_mem #(
    parameter int N_PE  = pea_pkg::N_PE,
    parameter int N_CTX = pea_pkg::N_CTX,
    parameter int CFG_W = pea_pkg::N_CFG_BITS_PE
) (
    input  logic                      clk_i,
    input  logic                      i_we,
    input  logic [$clog2(N_CTX)-1:0]  i_wr_ctx,
    input  logic [$clog2(N_PE)-1:0]   i_wr_pe,
    input  logic [CFG_W-1:0]          i_wr_data,
    input  logic [$clog2(N_CTX)-1:0]  i_rd_ctx,
    output logic [N_PE*CFG_W-1:0]     o_rd_row
);

    logic [N_PE-1:0][CFG_W-1:0] r_mem [N_CTX];
    logic [N_PE-1:0][CFG_W-1:0] w_row;

    // NOTE: storage has no reset; the host always loads a context before running it, and
    // leaving it unreset lets it map onto plain flops or a register file.
    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_wr_ctx][i_wr_pe] <= i_wr_data;
        end
    end

    // NOTE: w_row gets its full default before the conditional patch, so no latch is inferred.
    always_comb begin
        w_row = r_mem[i_rd_ctx];
        if (i_we && (i_wr_ctx == i_rd_ctx)) begin
            w_row[i_wr_pe] = i_wr_data;
        end
    end

    assign o_rd_row = w_row;

endmodule

// File: rtl/pea_ctx_sched.sv
// PEA context scheduler: steps through the active contexts for a programmed number of
// iterations, holds on array back-pressure, drains with NOP words and then reports done.
module pea_ctx_sched #(
    parameter int N_PE    = pea_pkg::N_PE,
    parameter int N_CTX   = pea_pkg::N_CTX,
    parameter int CFG_W   = pea_pkg::N_CFG_BITS_PE,
    parameter int ITER_W  = pea_pkg::ITER_W,
    parameter int DRAIN_W = pea_pkg::DRAIN_W
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    pea_ctx_sched_if.slave  bus
);

    import pea_pkg::*;

    localparam int CTX_W = $clog2(N_CTX);
    localparam int ROW_W = N_PE * CFG_W;
    localparam logic [ROW_W-1:0] ROW_NOP = {N_PE{CFG_W'(CTRL_NOP)}};

    pea_sched_state_t   r_state;
    pea_sched_state_t   w_state_nxt;

    logic [CTX_W-1:0]   r_ctx;
    logic [CTX_W-1:0]   w_ctx_nxt;
    logic [ITER_W-1:0]  r_iter;
    logic [ITER_W-1:0]  w_iter_nxt;
    logic [DRAIN_W-1:0] r_drain;
    logic [DRAIN_W-1:0] w_drain_nxt;

    logic [CTX_W-1:0]   r_n_ctx;
    logic [ITER_W-1:0]  r_n_iter;
    logic [DRAIN_W-1:0] r_n_drain;

    logic [ROW_W-1:0]   r_ctrl;
    logic [ROW_W-1:0]   w_ctrl_nxt;
    logic [ROW_W-1:0]   w_row;

    logic               w_latch;
    logic               w_load_row;
    logic               w_hold_row;
    logic               w_mem_we;
    logic               r_cfg_err;

    // Writes are only accepted while idle so a running schedule never sees a torn row.
    assign w_mem_we = bus.cfg_we_i && (r_state == IDLE);

    // The read index is the context about to be presented, giving one cycle index-to-output.
    pea_ctx_mem #(
        .N_PE  (N_PE),
        .N_CTX (N_CTX),
        .CFG_W (CFG_W)
    ) u_mem (
        .clk_i     (clk_i),
        .i_we      (w_mem_we),
        .i_wr_ctx  (bus.cfg_ctx_i),
        .i_wr_pe   (bus.cfg_pe_i),
        .i_wr_data (bus.cfg_data_i),
        .i_rd_ctx  (w_ctx_nxt),
        .o_rd_row  (w_row)
    );

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ctx_nxt   = r_ctx;
        w_iter_nxt  = r_iter;
        w_drain_nxt = r_drain;
        w_latch     = 1'b0;
        w_load_row  = 1'b0;
        w_hold_row  = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start_i) begin
                    w_latch    = 1'b1;
                    w_ctx_nxt  = '0;
                    w_iter_nxt = '0;
                    if (bus.n_iter_i != '0) begin
                        w_state_nxt = RUN;
                        w_load_row  = 1'b1;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end

            RUN: begin
                if (bus.stop_i) begin
                    w_state_nxt = IDLE;
                end else if (!bus.pea_ready_i) begin
                    w_hold_row = 1'b1;
                end else if (r_ctx != r_n_ctx) begin
                    w_ctx_nxt  = r_ctx + 1'b1;
                    w_load_row = 1'b1;
                end else if (r_iter != (r_n_iter - 1'b1)) begin
                    w_ctx_nxt  = '0;
                    w_iter_nxt = r_iter + 1'b1;
                    w_load_row = 1'b1;
                end else begin
                    w_state_nxt = DRAIN;
                    w_ctx_nxt   = '0;
                    w_iter_nxt  = r_iter + 1'b1;
                    w_drain_nxt = r_n_drain;
                end
            end

            DRAIN: begin
                if (bus.stop_i) begin
                    w_state_nxt = IDLE;
                end else if (bus.pea_ready_i) begin
                    if (r_drain == '0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_drain_nxt = r_drain - 1'b1;
                    end
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Anything that is neither a fresh context nor a stall hold presents NOP to the array.
    assign w_ctrl_nxt = w_load_row ? w_row :
                        w_hold_row ? r_ctrl : ROW_NOP;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ctx     <= '0;
            r_iter    <= '0;
            r_drain   <= '0;
            r_n_ctx   <= '0;
            r_n_iter  <= '0;
            r_n_drain <= '0;
            r_ctrl    <= ROW_NOP;
            r_cfg_err <= 1'b0;
        end else begin
            r_ctx     <= w_ctx_nxt;
            r_iter    <= w_iter_nxt;
            r_drain   <= w_drain_nxt;
            r_ctrl    <= w_ctrl_nxt;
            r_cfg_err <= bus.cfg_we_i && (r_state != IDLE);
            if (w_latch) begin
                r_n_ctx   <= bus.n_ctx_i;
                r_n_iter  <= bus.n_iter_i;
                r_n_drain <= bus.n_drain_i;
            end
        end
    end

    assign bus.ctrl_pe_o  = r_ctrl;
    assign bus.ctx_idx_o  = r_ctx;
    assign bus.iter_cnt_o = r_iter;
    assign bus.busy_o     = (r_state == RUN) || (r_state == DRAIN);
    assign bus.done_o     = (r_state == DONE);
    assign bus.cfg_err_o  = r_cfg_err;

endmodule

// File: tb/tb_pea_ctx_sched.sv
// Self-checking bench for pea_ctx_sched: table of run scenarios scored cycle by cycle, plus
// hand-written sequences for bypass, rejected writes and asynchronous reset.
module tb_pea_ctx_sched;

    import pea_pkg::*;

    localparam int ROW_W = N_PE * N_CFG_BITS_PE;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pea_ctx_sched_if bus ();

    pea_ctx_sched dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [ROW_W-1:0] ctrl;
        int               ctx;
        int               iter;
        bit               busy;
        bit               done;
        bit               chk_ctx;
        bit               chk_iter;
    } exp_t;

    typedef struct {
        string name;
        int    n_ctx;
        int    n_iter;
        int    n_drain;
        int    stall_from;
        int    stall_len;
        int    stop_at;
        int    done_at;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t steps[$];
    vec_t vecs[6];
    logic [N_CFG_BITS_PE-1:0] tb_mem [N_CTX][N_PE];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [ROW_W-1:0] row_of(input int c);
        logic [ROW_W-1:0] r;
        for (int p = 0; p < N_PE; p++) r[p*N_CFG_BITS_PE +: N_CFG_BITS_PE] = tb_mem[c][p];
        return r;
    endfunction

    function automatic exp_t mk(input logic [ROW_W-1:0] ctrl, input int ctx, input int iter,
                                input bit busy, input bit done, input bit chk_ctx, input bit chk_iter);
        exp_t e;
        e.ctrl = ctrl; e.ctx = ctx; e.iter = iter; e.busy = busy; e.done = done;
        e.chk_ctx = chk_ctx; e.chk_iter = chk_iter;
        return e;
    endfunction

    function automatic logic [255:0] pack(input exp_t m, input logic [ROW_W-1:0] ctrl,
                                          input logic [LOG_N_CTX-1:0] ctx, input logic [ITER_W-1:0] iter,
                                          input logic busy, input logic done);
        logic [LOG_N_CTX-1:0] c;
        logic [ITER_W-1:0]    i;
        c = m.chk_ctx  ? ctx  : '0;
        i = m.chk_iter ? iter : '0;
        return 256'({ctrl, c, i, busy, done});
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cfg_write(input int c, input int p, input int data);
        bus.cfg_we_i   = 1'b1;
        bus.cfg_ctx_i  = LOG_N_CTX'(c);
        bus.cfg_pe_i   = LOG_N_PE'(p);
        bus.cfg_data_i = N_CFG_BITS_PE'(data);
        tick();
        bus.cfg_we_i   = 1'b0;
        tb_mem[c][p]   = N_CFG_BITS_PE'(data);
    endtask

    task automatic set_run(input int n_ctx, input int n_iter, input int n_drain);
        bus.n_ctx_i   = LOG_N_CTX'(n_ctx);
        bus.n_iter_i  = ITER_W'(n_iter);
        bus.n_drain_i = DRAIN_W'(n_drain);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick();
            if (bus.done_o) seen = 1'b1;
        end
        check({name, " done"}, 256'(seen), 256'(1));
        tick();
    endtask

    // Expected output sequence: each context of each iteration, drain cycles, done, idle.
    task automatic build_steps(input vec_t v);
        steps.delete();
        for (int it = 0; it < v.n_iter; it++)
            for (int c = 0; c <= v.n_ctx; c++)
                steps.push_back(mk(row_of(c), c, it, 1'b1, 1'b0, 1'b1, 1'b1));
        if (v.n_iter > 0)
            for (int d = 0; d <= v.n_drain; d++)
                steps.push_back(mk('0, 0, v.n_iter, 1'b1, 1'b0, 1'b0, 1'b1));
        steps.push_back(mk('0, 0, v.n_iter, 1'b0, 1'b1, 1'b0, 1'b1));
        steps.push_back(mk('0, 0, v.n_iter, 1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic run_vec(input vec_t v);
        int   p         = 0;
        int   done_seen = -1;
        bit   aborted   = 1'b0;
        int   limit;
        exp_t e;
        exp_t g;
        build_steps(v);
        limit = (v.done_at >= 0) ? v.done_at + 1 : v.stop_at + 2;
        set_run(v.n_ctx, v.n_iter, v.n_drain);
        for (int t = 0; t <= limit; t++) begin
            bus.start_i     = (t == 0);
            bus.pea_ready_i = !(t >= v.stall_from && t < v.stall_from + v.stall_len);
            bus.stop_i      = (t == v.stop_at);
            if (t > 0 && !aborted) begin
                if (bus.stop_i) aborted = 1'b1;
                else if ((bus.pea_ready_i || steps[p].done) && p < steps.size() - 1) p++;
            end
            e = aborted ? mk('0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0) : steps[p];
            sb.push_back(e);
            tick();
            g = sb.pop_front();
            check($sformatf("%s t%0d", v.name, t),
                  pack(g, bus.ctrl_pe_o, bus.ctx_idx_o, bus.iter_cnt_o, bus.busy_o, bus.done_o),
                  pack(g, g.ctrl, LOG_N_CTX'(g.ctx), ITER_W'(g.iter), g.busy, g.done));
            if (bus.done_o && done_seen < 0) done_seen = t;
        end
        bus.start_i     = 1'b0;
        bus.stop_i      = 1'b0;
        bus.pea_ready_i = 1'b1;
        check({v.name, " done_at"}, 256'(done_seen), 256'(v.done_at));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           name      n_ctx n_iter n_drain stall_from stall_len stop_at done_at
        vecs[0] = '{"plain",     2,    3,     2,      -1,        0,       -1,     12};
        vecs[1] = '{"stall",     2,    3,     2,       2,        4,       -1,     16};
        vecs[2] = '{"abort",     2,    3,     2,      -1,        0,        6,     -1};
        vecs[3] = '{"allctx",    7,    2,     0,      17,        2,       -1,     19};
        vecs[4] = '{"onectx",    0,    4,     0,      -1,        0,       -1,      5};
        vecs[5] = '{"zeroiter",  2,    0,     3,      -1,        0,       -1,      0};

        bus.cfg_we_i    = 1'b0;
        bus.cfg_ctx_i   = '0;
        bus.cfg_pe_i    = '0;
        bus.cfg_data_i  = '0;
        bus.start_i     = 1'b0;
        bus.stop_i      = 1'b0;
        bus.pea_ready_i = 1'b1;
        set_run(0, 0, 0);

        #22;
        check("reset outputs",
              {bus.ctrl_pe_o, bus.ctx_idx_o, bus.iter_cnt_o, bus.busy_o, bus.done_o, bus.cfg_err_o}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int c = 0; c < N_CTX; c++)
            for (int p = 0; p < N_PE; p++)
                cfg_write(c, p, c * 16 + p);
        check("idle write no err", 256'(bus.cfg_err_o), 256'(0));

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Write and start together: the first presented row must already carry the new word.
        bus.cfg_we_i   = 1'b1;
        bus.cfg_ctx_i  = '0;
        bus.cfg_pe_i   = '0;
        bus.cfg_data_i = 8'hA5;
        set_run(0, 1, 0);
        bus.start_i    = 1'b1;
        tick();
        bus.cfg_we_i   = 1'b0;
        bus.start_i    = 1'b0;
        tb_mem[0][0]   = 8'hA5;
        check("bypass row", 256'(bus.ctrl_pe_o), 256'(row_of(0)));
        wait_done("bypass", 10);

        // Write while busy is dropped and flagged for exactly one cycle.
        set_run(0, 100, 0);
        bus.start_i    = 1'b1;
        tick();
        bus.start_i    = 1'b0;
        bus.cfg_we_i   = 1'b1;
        bus.cfg_ctx_i  = '0;
        bus.cfg_pe_i   = '0;
        bus.cfg_data_i = 8'h3F;
        tick();
        bus.cfg_we_i   = 1'b0;
        check("reject err pulse", 256'(bus.cfg_err_o), 256'(1));
        tick();
        check("reject err single", 256'(bus.cfg_err_o), 256'(0));
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
        check("stop outputs", 256'({bus.ctrl_pe_o, bus.busy_o, bus.done_o}), '0);
        set_run(0, 1, 0);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check("reject kept word", 256'(bus.ctrl_pe_o), 256'(row_of(0)));
        check("restart iter", 256'(bus.iter_cnt_o), 256'(0));
        wait_done("after reject", 10);

        // Asynchronous reset in the middle of a run clears outputs without waiting for a clock.
        set_run(2, 100, 0);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        repeat (4) tick();
        check("pre-reset busy", 256'({bus.busy_o, bus.iter_cnt_o}), 256'({1'b1, 16'd1}));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset outputs",
              {bus.ctrl_pe_o, bus.ctx_idx_o, bus.iter_cnt_o, bus.busy_o, bus.done_o, bus.cfg_err_o}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle after reset", 256'({bus.ctrl_pe_o, bus.busy_o, bus.done_o}), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
